// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and control-state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_param_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// o_done pulses for one cycle when o_product holds the full 2*WIDTH-bit result.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    // Operand capture, per-cycle accumulate/shift, and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_acc    <= {(2*WIDTH){1'b0}};
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_cnt    <= CW'(WIDTH - 1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt - CW'(1);
                if (r_cnt == {CW{1'b0}}) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready handshakes; single-cycle ops finish in one
// cycle, MUL is handed to the iterative multiplier and stalls the producer.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             Z,
    output logic             N,
    output logic             M
);

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_f;
    logic               r_cout;
    logic               r_z;
    logic               r_n;
    logic               r_m;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ovf;

    assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_is_mul = (opcode == OP_MUL);
    assign w_shamt  = B[SHW-1:0];
    assign w_mul_lo = w_product[WIDTH-1:0];

    // One extra bit on both adders exposes the carry / no-borrow
    assign w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign w_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept & w_is_mul),
        .i_a       (A),
        .i_b       (B),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Single-cycle result, carry and overflow for the presented opcode
    always_comb begin
        w_res  = {WIDTH{1'b0}};
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NOR:  w_res = ~(A | B);
            OP_SLL:  w_res = A << w_shamt;
            OP_SRL:  w_res = A >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(A) >>> w_shamt);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM with registered result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_f         <= {WIDTH{1'b0}};
            r_cout      <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_m         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= ST_EXEC;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_f         <= w_res;
                            r_cout      <= w_cout;
                            r_z         <= (w_res == {WIDTH{1'b0}});
                            r_n         <= w_res[WIDTH-1];
                            r_m         <= w_ovf;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_mul_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_f         <= w_mul_lo;
                        r_cout      <= |w_product[2*WIDTH-1:WIDTH];
                        r_z         <= (w_mul_lo == {WIDTH{1'b0}});
                        r_n         <= w_mul_lo[WIDTH-1];
                        r_m         <= 1'b0;
                    end else if (!w_mul_busy) begin
                        // Multiplier idle without a result: recover rather than hang
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign F         = r_f;
    assign Cout      = r_cout;
    assign Z         = r_z;
    assign N         = r_n;
    assign M         = r_m;

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param: directed corner cases plus random traffic
// with random back-pressure, checked against an arithmetic reference model.
module tb_alu_seq_param;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c;
        logic         z;
        logic         n;
        logic         m;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   opcode;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] F;
    logic         Cout;
    logic         Z;
    logic         N;
    logic         M;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   rand_rdy = 1'b0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .Cout(Cout), .Z(Z), .N(N), .M(M)
    );

    always #5 clk = ~clk;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] w;
        int          sh;
        e  = '0;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[4:0]);
        case (op)
            4'd0: begin
                w = 64'(a) + 64'(b) + 64'(cin);
                e.f = w[31:0]; e.c = w[32];
                sr = sa + sb + longint'(cin);
                e.m = (sr > MAXS) || (sr < MINS);
            end
            4'd1: begin
                e.f = a - b; e.c = (a >= b);
                sr = sa - sb;
                e.m = (sr > MAXS) || (sr < MINS);
            end
            4'd2:  e.f = a & b;
            4'd3:  e.f = a | b;
            4'd4:  e.f = a ^ b;
            4'd5:  e.f = ~(a | b);
            4'd6:  e.f = a << sh;
            4'd7:  e.f = a >> sh;
            4'd8:  e.f = $unsigned($signed(a) >>> sh);
            4'd9:  e.f = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: e.f = (a < b) ? 32'd1 : 32'd0;
            4'd11: begin
                w = 64'(a) * 64'(b);
                e.f = w[31:0]; e.c = (w[63:32] != 32'd0);
            end
            default: e.f = 32'd0;
        endcase
        e.z = (e.f == 32'd0);
        e.n = e.f[31];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: a result is consumed when out_valid & out_ready at the edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 64'(F), 64'hDEAD_0000_0000_0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 64'({F, Cout, Z, N, M}), 64'(e));
            end
        end
    end

    // Random back-pressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drive one op from just after an edge; returns just after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit push);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1; opcode = op; A = a; B = b; Cin = cin;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) q.push_back(model(op, a, b, cin));
                acc = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        A = $urandom; B = $urandom; opcode = 4'($urandom); Cin = 1'($urandom);
        check("issue_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   k;
        int   first;
        bit   bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 32'd0; B = 32'd0; opcode = 4'd0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({out_valid, F, Cout, Z, N, M, in_ready}), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases through the scoreboard
        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("add_latency1", 64'(out_valid), 64'd1);
        check("add_wrap_value", 64'({F, Cout, Z, M}), {28'd0, 32'h0, 1'b1, 1'b1, 1'b0});
        issue(4'd1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        issue(4'd8, 32'h8000_0000, 32'h0000_0024, 1'b0, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'h0000_0024, 1'b0, 1'b1);
        issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
        drain();

        // MUL latency: out_valid first seen exactly 33 edges after accept
        issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        first = 0; bad = 1'b0;
        for (k = 1; k <= 40 && first == 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) first = k;
            else if (in_ready) bad = 1'b1;
        end
        check("mul_latency", 64'(first), 64'd33);
        check("mul_in_ready_low", 64'(bad), 64'd0);
        drain();

        // Back-pressure: result held stable, in_ready low while out_ready=0
        out_ready = 1'b0;
        issue(4'd4, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b0, 1'b1);
        e = model(4'd4, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("backpressure_hold", 64'({out_valid, in_ready, F, Cout, Z, N, M}),
                  64'({1'b1, 1'b0, e}));
        end
        out_ready = 1'b1;
        #1;
        check("done_ready_accept", 64'(in_ready), 64'd1);
        issue(4'd0, 32'h0000_0007, 32'h0000_0009, 1'b1, 1'b1);
        drain();

        // Reset mid-MUL aborts the operation; nothing must be presented
        issue(4'd11, 32'h0000_0123, 32'h0000_0456, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_mid_mul", 64'({out_valid, F, in_ready}), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("no_stale_mul", 64'(out_valid), 64'd0);
        issue(4'd0, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1);
        drain();

        // Random traffic with random back-pressure and idle gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
            if (op == 4'd11 && $urandom_range(0, 1) == 0) op = 4'd0;
            issue(op, pick(), pick(), 1'($urandom), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
